// File: rtl/burst_frame_packer_pkg.sv
// Shared definitions for the burst frame packer and the gather stage.
//   WORD_W         : sample / frame word width
//   HEADER_DEFAULT : sync word that opens every frame
//   state_e        : packer FSM states
//   frame_word_t   : one output word with its framing flags
package burst_frame_packer_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] HEADER_DEFAULT = 16'hEB90;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_CNT     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [WORD_W-1:0] data;
  } frame_word_t;

endpackage

// File: rtl/burst_frame_packer_checksum.sv
// 16-bit modular accumulator for the frame checksum.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : clear to zero (highest priority)
//   seed_en_i  : load seed_i
//   add_en_i   : accumulate add_val_i
//   sum_o      : registered running sum
module burst_frame_packer_checksum
  import burst_frame_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              seed_en_i,
  input  logic [WORD_W-1:0] seed_i,
  input  logic              add_en_i,
  input  logic [WORD_W-1:0] add_val_i,
  output logic [WORD_W-1:0] sum_o
);

  logic [WORD_W-1:0] sum_d, sum_q;

  // Next sum: clear, then seed, then add
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (seed_en_i) begin
      sum_d = seed_i;
    end else if (add_en_i) begin
      sum_d = sum_q + add_val_i;
    end
  end

  // Sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/burst_frame_packer.sv
// Drains one DEPTH-word burst from the gather FIFO whenever it reports full
// and emits it as a framed valid/ready stream: header, frame counter,
// payload, checksum.
//   clk, rst_n          : clock, async active-low reset
//   fifo_full, fifo_q   : gather FIFO status and read data (1-cycle latency)
//   rdreq               : FIFO read strobe (combinational)
//   out_data/valid/ready: framed word stream handshake
//   out_sof, out_eof    : flag header / checksum word
//   busy                : any state other than IDLE
//   frame_done          : one-cycle pulse after the checksum is accepted
//   frame_cnt           : completed frame count, wraps
module burst_frame_packer
  import burst_frame_packer_pkg::*;
#(
  parameter int unsigned       DEPTH  = 256,
  parameter logic [WORD_W-1:0] HEADER = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_full,
  input  logic [WORD_W-1:0] fifo_q,
  output logic              rdreq,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic [WORD_W-1:0] frame_cnt
);

  // Wide enough to hold DEPTH itself for the largest legal DEPTH
  localparam int unsigned CNT_W = 17;

  state_e            state_d, state_q;
  frame_word_t       word_d, word_q;
  logic              valid_d, valid_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  rd_cnt_d, rd_cnt_q;
  logic [WORD_W-1:0] frame_cnt_d, frame_cnt_q;
  logic              done_d, done_q;
  logic              busy_q;
  logic              accept;
  logic              ck_clr, ck_seed, ck_add;
  logic [WORD_W-1:0] ck_sum;

  assign accept = valid_q & out_ready;

  // One read outstanding at most, and only when its word has a free slot
  assign rdreq = (state_q == ST_PAYLOAD) && (rd_cnt_q < CNT_W'(DEPTH)) &&
                 !inflight_q && (!valid_q || out_ready);

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    valid_d     = valid_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    ck_clr      = 1'b0;
    ck_seed     = 1'b0;
    ck_add      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_full) begin
          state_d  = ST_HDR;
          word_d   = '{sof: 1'b1, eof: 1'b0, data: HEADER};
          valid_d  = 1'b1;
          rd_cnt_d = '0;
        end
      end

      ST_HDR: begin
        if (accept) begin
          state_d = ST_CNT;
          word_d  = '{sof: 1'b0, eof: 1'b0, data: frame_cnt_q};
          ck_seed = 1'b1;
        end
      end

      ST_CNT: begin
        if (accept) begin
          state_d = ST_PAYLOAD;
          valid_d = 1'b0;
        end
      end

      ST_PAYLOAD: begin
        // The word returned by last cycle's read always lands in an empty slot
        if (inflight_q) begin
          word_d.data = fifo_q;
          valid_d     = 1'b1;
          ck_add      = 1'b1;
        end else if (accept) begin
          if (rd_cnt_q == CNT_W'(DEPTH)) begin
            state_d = ST_CSUM;
            word_d  = '{sof: 1'b0, eof: 1'b1, data: ck_sum};
          end else begin
            valid_d = 1'b0;
          end
        end
        if (rdreq) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end

      ST_CSUM: begin
        if (accept) begin
          state_d     = ST_IDLE;
          valid_d     = 1'b0;
          word_d.eof  = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          done_d      = 1'b1;
          ck_clr      = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      valid_q     <= 1'b0;
      inflight_q  <= 1'b0;
      rd_cnt_q    <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      inflight_q  <= rdreq;
      rd_cnt_q    <= rd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Running checksum seeded with the counter word
  burst_frame_packer_checksum u_checksum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ck_clr),
    .seed_en_i (ck_seed),
    .seed_i    (frame_cnt_q),
    .add_en_i  (ck_add),
    .add_val_i (fifo_q),
    .sum_o     (ck_sum)
  );

  assign out_data   = word_q.data;
  assign out_sof    = word_q.sof;
  assign out_eof    = word_q.eof;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_burst_frame_packer.sv
// Self-checking bench for burst_frame_packer (DEPTH=4): frame-level reference
// model, FIFO model and one negedge compare process, plus directed literals.
module tb_burst_frame_packer;
  import burst_frame_packer_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int          DEPTH_I = 4;
  localparam logic [15:0] HDR     = 16'hEB90;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_full = 1'b0;
  logic [15:0] fifo_q = '0;
  logic        rdreq;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sof, out_eof, busy, frame_done;
  logic [15:0] frame_cnt;

  burst_frame_packer #(.DEPTH(DEPTH), .HEADER(HDR)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_full(fifo_full), .fifo_q(fifo_q),
    .rdreq(rdreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected words are {sof, eof, data}
  typedef logic [17:0] ent_t;
  ent_t        exp_q[$];
  ent_t        e;
  logic [15:0] pay_src[$];
  logic [15:0] log_q[$];
  logic [15:0] cur_pay [DEPTH];
  logic [15:0] model_frames = '0;
  logic [15:0] sum;
  bit          model_active = 0, done_exp = 0, hdr_exp = 0;
  bit          prev_stall = 0, prev_rdreq = 0;
  logic [17:0] prev_word = '0;
  int          reads = 0, cyc = 0, last_eof_cyc = 0, last_gap = 0;
  int          ready_mode = 0;

  // Sink ready: always 1 or random per cycle
  initial forever begin
    @(posedge clk); #1;
    out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Compare process: checks every cycle, models the FIFO read port
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(model_active));
      chk("frame_done", 32'(frame_done), 32'(done_exp));
      chk("frame_cnt", 32'(frame_cnt), 32'(model_frames));
      done_exp = 0;
      if (hdr_exp) begin
        chk("start_latency", 32'({out_valid, out_sof, out_data}), 32'({1'b1, 1'b1, HDR}));
        hdr_exp = 0;
      end
      if (prev_stall)
        chk("hold", 32'({out_valid, out_sof, out_eof, out_data}), 32'({1'b1, prev_word}));
      if (rdreq)
        chk("rdreq_legal", 32'(prev_rdreq || !model_active || reads >= DEPTH_I ||
                               (out_valid && !out_ready)), 32'd0);
      if (!model_active && fifo_full) begin
        sum = model_frames;
        exp_q.push_back({1'b1, 1'b0, HDR});
        exp_q.push_back({1'b0, 1'b0, model_frames});
        for (int i = 0; i < DEPTH_I; i++) begin
          cur_pay[i] = (pay_src.size() > 0) ? pay_src.pop_front() : 16'($urandom);
          exp_q.push_back({1'b0, 1'b0, cur_pay[i]});
          sum = sum + cur_pay[i];
        end
        exp_q.push_back({1'b0, 1'b1, sum});
        model_active = 1;
        hdr_exp = 1;
        reads = 0;
        last_gap = cyc - last_eof_cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_word: got %h, expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'({out_sof, out_eof, out_data}), 32'(e));
          log_q.push_back(out_data);
          if (e[16]) begin
            chk("reads_per_frame", 32'(reads), 32'(DEPTH));
            model_active = 0;
            model_frames = model_frames + 16'd1;
            done_exp = 1;
            last_eof_cyc = cyc;
          end
        end
      end
      if (rdreq) begin
        fifo_q = (reads < DEPTH_I) ? cur_pay[reads] : 16'hDEAD;
        reads++;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sof, out_eof, out_data};
      prev_rdreq = rdreq;
    end
  end

  task automatic pulse_full();
    fifo_full = 1'b1;
    @(posedge clk); #1;
    fifo_full = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((model_active || exp_q.size() != 0) && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    if (model_active || exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: frame still open after %0d cycles, expected completion", budget);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int budget);
    log_q.delete();
    pulse_full();
    wait_idle(budget);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    v = (idx < log_q.size()) ? log_q[idx] : 16'hXXXX;
    chk(name, 32'(v), 32'(exp));
  endtask

  logic [15:0] exp1 [7];
  int k;
  logic [15:0] f0;

  initial begin
    exp1 = '{16'hEB90, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};

    // Async reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_flags", 32'({rdreq, out_valid, out_sof, out_eof, busy, frame_done}), 32'd0);
    chk("rst_data", 32'({out_data, frame_cnt}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: payload 1..4
    for (int i = 1; i <= 4; i++) pay_src.push_back(16'(i));
    run_frame(100);
    chk("f1_len", 32'(log_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) chk_log("f1_word", i, exp1[i]);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Frame 2: payload FFFF x4
    for (int i = 0; i < 4; i++) pay_src.push_back(16'hFFFF);
    run_frame(100);
    chk_log("f2_cnt_word", 1, 16'h0001);
    chk_log("f2_csum", 6, 16'hFFFD);

    // Random back-pressure, random payload
    ready_mode = 1;
    for (int f = 0; f < 6; f++) run_frame(400);
    ready_mode = 0;

    // fifo_full dropped after the first read
    log_q.delete();
    fifo_full = 1'b1;
    k = 0;
    while (!(model_active && reads >= 1) && k < 100) begin @(posedge clk); #1; k++; end
    fifo_full = 1'b0;
    wait_idle(100);
    chk("drop_len", 32'(log_q.size()), 32'd7);

    // fifo_full held through the checksum: back-to-back frames
    f0 = model_frames;
    fifo_full = 1'b1;
    k = 0;
    while (!(model_frames == f0 + 16'd1 && model_active) && k < 200) begin
      @(posedge clk); #1; k++;
    end
    fifo_full = 1'b0;
    chk("b2b_gap", 32'(last_gap), 32'd1);
    wait_idle(100);

    // Reset during the third payload read
    pulse_full();
    k = 0;
    while (!(rdreq && reads == 3) && k < 200) begin @(negedge clk); #1; k++; end
    chk("reached_third_read", 32'(reads), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 32'({rdreq, out_valid, out_sof, out_eof, busy, frame_done}), 32'd0);
    chk("midrst_data", 32'({out_data, frame_cnt}), 32'd0);
    model_active = 0; exp_q.delete(); model_frames = '0; done_exp = 0; hdr_exp = 0;
    prev_stall = 0; prev_rdreq = 0; reads = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(100);
    chk_log("post_rst_cnt_word", 1, 16'h0000);

    // Counter wrap: force FFFF while idle
    force dut.frame_cnt_q = 16'hFFFF;
    model_frames = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    run_frame(100);
    chk_log("wrap_cnt_word", 1, 16'hFFFF);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
    run_frame(100);
    chk_log("after_wrap_cnt_word", 1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
